imem_boot_loader: RTL

- Write-side counterpart of the instruction fetch path. The core only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver, and assembles 32-bit little-endian words.
- Writes those words sequentially into the instruction memory write port.
- Holds the core in reset until the full image has been written.

---
 rtl/boot_pkg.sv | 20 ++
 rtl/byte_to_word_packer.sv | 44 ++++
 rtl/imem_boot_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // First received byte of a word lands in bits [7:0].
    localparam bit BYTE_ORDER_LE = 1'b1;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles four consecutive bytes into a 32-bit word; word_valid_o pulses with the 4th byte.
module byte_to_word_packer
    import boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  slot;

    assign slot = BYTE_ORDER_LE ? idx_q : ~idx_q;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (valid_i) begin
            word_d[{slot, 3'b000} +: 8] = byte_i;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Fills instruction memory from a byte stream and holds the core in reset until the image is loaded.
// Define IMEM_BOOT_LOADER_CHKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_RESETn,
    output logic              busy,
    output logic              error
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [16:0] DEPTH_17 = 17'(DEPTH);

    boot_state_e       state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [15:0]       wcnt_inc;
    logic [15:0]       hdr_cnt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              error_q, error_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              accept;
    logic              pack_clear, pack_valid;
    logic [31:0]       pack_word;
    logic              word_valid;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    assign rx_ready = (state_q == IDLE) || (state_q == HDR0) || (state_q == HDR1)
                   || (state_q == DATA) || (state_q == CHK);
    assign accept   = rx_valid && rx_ready;
    assign busy     = (state_q == HDR0) || (state_q == HDR1)
                   || (state_q == DATA) || (state_q == WRITE);
    assign imem_we  = (state_q == WRITE);
    assign wcnt_inc = wcnt_q + 16'd1;
    assign hdr_cnt  = {rx_data, cnt_q[7:0]};

    byte_to_word_packer u_packer (
        .clk_i        (CLK),
        .rst_ni       (RESETn),
        .clear_i      (pack_clear),
        .valid_i      (pack_valid),
        .byte_i       (rx_data),
        .word_o       (pack_word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        addr_d      = addr_q;
        error_d     = error_q;
        pack_clear  = 1'b0;
        pack_valid  = 1'b0;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
        chk_d       = chk_q;
`endif
        // Registered so the core leaves reset one cycle after DONE is entered.
        cpu_rst_n_d = (state_q == DONE) && !load_req;

        case (state_q)
            IDLE: begin
                pack_clear = 1'b1;
                if (accept && rx_data == SYNC_BYTE) state_d = HDR0;
            end
            HDR0: begin
                pack_clear = 1'b1;
                if (accept) begin
                    cnt_d[7:0] = rx_data;
                    state_d    = HDR1;
                end
            end
            HDR1: begin
                pack_clear = 1'b1;
                if (accept) begin
                    cnt_d = hdr_cnt;
                    if (hdr_cnt == 16'd0) begin
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
                        chk_d   = '0;
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else if ({1'b0, hdr_cnt} > DEPTH_17) begin
                        error_d = 1'b1;
                        state_d = ERROR;
                    end else begin
                        wcnt_d  = '0;
                        addr_d  = '0;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
                        chk_d   = '0;
`endif
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                pack_valid = accept;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
                if (accept) chk_d = chk_q ^ rx_data;
`endif
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                addr_d = addr_q + 1'b1;
                wcnt_d = wcnt_inc;
                if (wcnt_inc == cnt_q) begin
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
            CHK: begin
                if (accept) begin
                    if (rx_data == chk_q) begin
                        state_d = DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = ERROR;
                    end
                end
            end
`endif
            DONE, ERROR: begin
                if (load_req) begin
                    error_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            addr_q      <= '0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = pack_word;
    assign cpu_RESETn = cpu_rst_n_q;
    assign error      = error_q;

endmodule
